// File: rtl/rvx_perf_counters.sv
// Performance-monitor block: cycle, retired and NUM_EVENTS programmable event
// counters behind a 32-bit register port. Counter reads are tear-free when done
// as a low-word read followed by a high-word read (shared high-word shadow).
module rvx_perf_counters #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 48
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  retire_valid,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [31:0]           wr_data,
  input  logic                  rd_en,
  input  logic [4:0]            rd_addr,
  output logic [31:0]           rd_data,
  output logic                  ovf_irq
);

  localparam int NUM_CNT = NUM_EVENTS + 2;
  localparam logic [4:0] ADDR_CTRL  = 5'h18;
  localparam logic [4:0] ADDR_OVF   = 5'h19;
  localparam logic [4:0] ADDR_CLEAR = 5'h1A;
  localparam logic [CNT_WIDTH-1:0] LO_MASK = CNT_WIDTH'(64'hFFFF_FFFF);

  logic [CNT_WIDTH-1:0] cnt_val [NUM_CNT];
  logic [NUM_CNT-1:0]   en_reg;
  logic                 freeze_reg;
  logic [NUM_CNT-1:0]   ovf_reg, ovf_next, ovf_set;
  logic [31:0]          shadow_reg, shadow_next;
  logic [31:0]          rd_data_reg, rd_data_next;
  logic [31:0]          ctrl_word;
  logic [NUM_CNT-1:0]   evt;
  logic                 ctrl_wr, ovf_wr, clr_wr;

  // Counter 0 counts every cycle, counter 1 retirements, the rest event_i.
  assign evt     = {event_i, retire_valid, 1'b1};
  assign ctrl_wr = wr_en && (wr_addr == ADDR_CTRL);
  assign ovf_wr  = wr_en && (wr_addr == ADDR_OVF);
  assign clr_wr  = wr_en && (wr_addr == ADDR_CLEAR);
  assign ctrl_word = {freeze_reg, {(31-NUM_CNT){1'b0}}, en_reg};

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
      logic inc, wr_lo, wr_hi, clr;

      assign inc   = en_reg[gi] && !freeze_reg && evt[gi];
      assign wr_lo = wr_en && (wr_addr == 5'(2*gi));
      assign wr_hi = wr_en && (wr_addr == 5'(2*gi+1)) && (CNT_WIDTH > 32);
      assign clr   = clr_wr && wr_data[gi];
      // A wrap only happens when the increment is not displaced by a write.
      assign ovf_set[gi] = inc && !(wr_lo || wr_hi || clr) && (&cnt_reg);
      assign cnt_val[gi] = cnt_reg;

      // Next counter value: software writes displace (drop) this cycle's increment.
      always_comb begin
        cnt_next = cnt_reg;
        if (clr)
          cnt_next = '0;
        else if (wr_lo)
          cnt_next = (cnt_reg & ~LO_MASK) | CNT_WIDTH'(wr_data);
        else if (wr_hi)
          cnt_next = (cnt_reg & LO_MASK) | (CNT_WIDTH'(wr_data) << 32);
        else if (inc)
          cnt_next = cnt_reg + 1'b1;
      end

      // Counter register.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_reg <= '0;
        else          cnt_reg <= cnt_next;
      end
    end
  endgenerate

  // Sticky overflow: a new wrap beats a same-cycle write-1-to-clear.
  always_comb begin
    ovf_next = ovf_reg & ~(ovf_wr ? wr_data[NUM_CNT-1:0] : {NUM_CNT{1'b0}});
    ovf_next = ovf_next | ovf_set;
  end

  // Read mux: samples pre-write state; low-word reads refresh the shared shadow.
  always_comb begin
    rd_data_next = rd_data_reg;
    shadow_next  = shadow_reg;
    if (rd_en) begin
      rd_data_next = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        if (rd_addr == 5'(2*i)) begin
          rd_data_next = cnt_val[i][31:0];
          shadow_next  = 32'(cnt_val[i] >> 32);
        end
        if (rd_addr == 5'(2*i+1))
          rd_data_next = shadow_reg;
      end
      if (rd_addr == ADDR_CTRL) rd_data_next = ctrl_word;
      if (rd_addr == ADDR_OVF)  rd_data_next = 32'(ovf_reg);
    end
  end

  // Control, overflow, shadow and read-data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_reg      <= '1;
      freeze_reg  <= 1'b0;
      ovf_reg     <= '0;
      shadow_reg  <= '0;
      rd_data_reg <= '0;
    end else begin
      if (ctrl_wr) begin
        en_reg     <= wr_data[NUM_CNT-1:0];
        freeze_reg <= wr_data[31];
      end
      ovf_reg     <= ovf_next;
      shadow_reg  <= shadow_next;
      rd_data_reg <= rd_data_next;
    end
  end

  assign rd_data = rd_data_reg;
  assign ovf_irq = |ovf_reg;

endmodule

// File: tb/tb_rvx_perf_counters.sv
// Directed bench for rvx_perf_counters: read results go through a scoreboard
// queue (pushed when the read is issued, popped when rd_data returns).
module tb_rvx_perf_counters;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        retire_valid;
  logic [3:0]  event_i;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        ovf_irq;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  rvx_perf_counters #(.NUM_EVENTS(4), .CNT_WIDTH(48)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .retire_valid (retire_valid),
    .event_i      (event_i),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .ovf_irq      (ovf_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_check();
    sb_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_empty: no expected entry for rd_data=%h", rd_data);
    end else begin
      e = sb_q.pop_front();
      assert (rd_data === e.exp) else begin
        n_errors++;
        $error("FAIL %s: rd_data=%h expected=%h", e.tag, rd_data, e.exp);
      end
      $display("check %s: rd_data=%h expected=%h", e.tag, rd_data, e.exp);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
    $display("check %s: got=%h expected=%h", tag, obs, exp);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    pop_check();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    $display("write addr=%h data=%h", a, d);
  endtask

  initial begin
    sb_t e;
    reset_n = 1'b0; retire_valid = 1'b0; event_i = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_irq", {31'b0, ovf_irq}, 32'h0);
    reset_n = 1'b1;

    // 10 cycles, retire_valid high in 6 of them
    for (int c = 0; c < 10; c++) begin
      retire_valid = (c < 6);
      tick();
    end
    retire_valid = 1'b0;
    rd(5'h00, 32'd10, "cycles_10");
    rd(5'h02, 32'd6, "retired_6");
    chk("irq_idle", {31'b0, ovf_irq}, 32'h0);
    rd(5'h18, 32'h0000_003F, "ctrl_reset");
    rd(5'h19, 32'h0, "ovf_reset");
    rd(5'h01, 32'h0, "cycles_hi");

    // Overflow on counter 2 (only counter 2 enabled)
    wr(5'h18, 32'h0000_0004);
    wr(5'h04, 32'hFFFF_FFFF);
    wr(5'h05, 32'hABCD_FFFF);
    rd(5'h04, 32'hFFFF_FFFF, "c2_lo_preset");
    rd(5'h05, 32'h0000_FFFF, "c2_hi_preset");
    event_i = 4'b0001;
    tick();
    event_i = 4'b0000;
    chk("irq_wrap", {31'b0, ovf_irq}, 32'h1);
    rd(5'h04, 32'h0, "c2_lo_wrapped");
    rd(5'h05, 32'h0, "c2_hi_wrapped");
    rd(5'h19, 32'h4, "ovf_bit2");
    wr(5'h19, 32'h4);
    chk("irq_w1c", {31'b0, ovf_irq}, 32'h0);
    rd(5'h19, 32'h0, "ovf_cleared");

    // Snapshot on counter 0 (only counter 0 enabled)
    wr(5'h18, 32'h0000_0001);
    wr(5'h00, 32'hFFFF_FFFE);
    wr(5'h01, 32'h0000_0001);
    rd(5'h00, 32'hFFFF_FFFE, "snap_lo");
    tick();
    rd(5'h01, 32'h1, "snap_hi_shadow");
    rd(5'h00, 32'h1, "snap_lo_again");
    rd(5'h01, 32'h2, "snap_hi_refresh");

    // Freeze: write cycle still counts (old CTRL), then everything stops
    wr(5'h18, 32'h8000_003F);
    retire_valid = 1'b1; event_i = 4'b0001;
    repeat (3) tick();
    retire_valid = 1'b0; event_i = 4'b0000;
    rd(5'h00, 32'h4, "frozen_c0");
    rd(5'h01, 32'h2, "frozen_c0_hi");
    rd(5'h02, 32'd6, "frozen_c1");
    rd(5'h04, 32'h0, "frozen_c2");

    // Mask 0b111101: counter 1 stops, others run
    wr(5'h18, 32'h0000_003D);
    retire_valid = 1'b1; event_i = 4'b0001;
    repeat (5) tick();
    retire_valid = 1'b0; event_i = 4'b0000;
    rd(5'h00, 32'd9, "mask_c0");
    rd(5'h02, 32'd6, "mask_c1");
    rd(5'h04, 32'd5, "mask_c2");
    rd(5'h18, 32'h0000_003D, "ctrl_mask");

    // CLEAR bit 0 while counting
    wr(5'h1A, 32'h1);
    rd(5'h00, 32'd0, "clr_c0_0");
    rd(5'h00, 32'd1, "clr_c0_1");
    rd(5'h00, 32'd2, "clr_c0_2");
    rd(5'h1A, 32'h0, "clear_reads_0");
    rd(5'h04, 32'd5, "clr_c2_kept");

    // W1C coinciding with a fresh wrap on bit 2
    wr(5'h04, 32'hFFFF_FFFF);
    wr(5'h05, 32'h0000_FFFF);
    event_i = 4'b0001;
    tick();
    event_i = 4'b0000;
    rd(5'h19, 32'h4, "ovf_first_wrap");
    wr(5'h04, 32'hFFFF_FFFF);
    wr(5'h05, 32'h0000_FFFF);
    wr_en = 1'b1; wr_addr = 5'h19; wr_data = 32'h4; event_i = 4'b0001;
    tick();
    wr_en = 1'b0; event_i = 4'b0000;
    chk("irq_set_wins", {31'b0, ovf_irq}, 32'h1);
    rd(5'h19, 32'h4, "ovf_set_wins");
    rd(5'h04, 32'h0, "c2_wrapped_again");

    // Read and write of the same address in one cycle -> old value
    e.tag = "rd_wr_same_old"; e.exp = 32'h0;
    sb_q.push_back(e);
    rd_en = 1'b1; rd_addr = 5'h04;
    wr_en = 1'b1; wr_addr = 5'h04; wr_data = 32'h1234_5678;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    pop_check();
    rd(5'h04, 32'h1234_5678, "rd_wr_same_new");

    // Reset asserted between rd_en and data return
    e.tag = "rst_mid_read"; e.exp = 32'h0;
    sb_q.push_back(e);
    rd_en = 1'b1; rd_addr = 5'h18;
    #2 reset_n = 1'b0;
    #1 pop_check();
    chk("rst_mid_irq", {31'b0, ovf_irq}, 32'h0);
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd(5'h00, 32'h0, "post_rst_c0");
    rd(5'h18, 32'h0000_003F, "post_rst_ctrl");
    rd(5'h19, 32'h0, "post_rst_ovf");
    rd(5'h04, 32'h0, "post_rst_c2");
    rd(5'h0C, 32'h0, "unmapped_0c");
    rd(5'h1F, 32'h0, "unmapped_1f");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
